// File: rtl/axis_stim_gen.sv
// AXI-Stream burst generator with a return-stream sink that counts beats,
// checks the TLAST position and flags an idle timeout.
module axis_stim_gen #(
    parameter int PRM_DAXI    = 64,
    parameter int PRM_COEF    = 32,
    parameter int PRM_BEATS_W = 12,
    parameter int PRM_TOUT_W  = 16
) (
    input  logic                     iSYS_CLK,
    input  logic                     iSYS_RST,
    input  logic                     iSTART,
    input  logic [1:0]               iMODE,
    input  logic [PRM_COEF-1:0]      iSEED,
    input  logic [PRM_BEATS_W-1:0]   iTX_BEATS,
    input  logic [PRM_BEATS_W-1:0]   iRX_BEATS,
    output logic                     oM_AXIS_TVALID,
    input  logic                     iM_AXIS_TREADY,
    output logic [PRM_DAXI-1:0]      oM_AXIS_TDATA,
    output logic [PRM_DAXI/8-1:0]    oM_AXIS_TKEEP,
    output logic                     oM_AXIS_TLAST,
    input  logic                     iS_AXIS_TVALID,
    output logic                     oS_AXIS_TREADY,
    input  logic [PRM_DAXI-1:0]      iS_AXIS_TDATA,
    input  logic                     iS_AXIS_TLAST,
    output logic                     oBUSY,
    output logic                     oDONE,
    output logic [PRM_BEATS_W-1:0]   oRX_CNT,
    output logic                     oERR,
    output logic                     oTIMEOUT,
    output logic [1:0]               oDBG_STATE
);

    localparam int LANES = PRM_DAXI / PRM_COEF;
    localparam logic [PRM_TOUT_W-1:0] TOUT_LAST = {{(PRM_TOUT_W-1){1'b1}}, 1'b0};

    // Both streams: a beat transfers on a rising edge where VALID and READY
    // are both high; a raised VALID holds with its payload until it transfers.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [1:0]             mode_q;
    logic [PRM_COEF-1:0]    seed_q;
    logic [PRM_BEATS_W-1:0] tx_beats_q;
    logic [PRM_BEATS_W-1:0] rx_beats_q;
    logic [PRM_BEATS_W-1:0] beat_q;
    logic [PRM_COEF-1:0]    base_q;
    logic                   m_tvalid_q;
    logic [PRM_DAXI-1:0]    m_tdata_q;
    logic                   m_tlast_q;
    logic [PRM_BEATS_W-1:0] rx_cnt_q;
    logic [PRM_BEATS_W-1:0] rx_cnt_nx;
    logic                   err_q;
    logic                   tout_flag_q;
    logic                   tlast_seen_q;
    logic [PRM_TOUT_W-1:0]  tout_cnt_q;

    logic start_go;
    logic m_acc;
    logic s_ready;
    logic rx_acc;
    logic ret_end;
    logic tout_hit;
    logic fin_tout;
    logic unused_rx_data;

    // Lane k of a beat whose first coefficient index is base carries V(base+k).
    function automatic logic [PRM_DAXI-1:0] pack_beat(
        input logic [1:0]          mode,
        input logic [PRM_COEF-1:0] seed,
        input logic [PRM_COEF-1:0] base
    );
        logic [PRM_DAXI-1:0] beat;
        logic [PRM_COEF-1:0] idx;
        logic [PRM_COEF-1:0] v;
        beat = '0;
        for (int k = 0; k < LANES; k++) begin
            idx = base + PRM_COEF'(k);
            case (mode)
                2'd0:    v = seed + idx;
                2'd1:    v = seed - idx;
                2'd2:    v = seed;
                default: v = idx[0] ? (PRM_COEF'(0) - seed) : seed;
            endcase
            beat[k*PRM_COEF +: PRM_COEF] = v;
        end
        return beat;
    endfunction

    assign start_go  = (state == ST_IDLE) && iSTART;
    assign m_acc     = m_tvalid_q && iM_AXIS_TREADY;
    assign s_ready   = (state == ST_SEND) || (state == ST_WAIT);
    assign rx_acc    = iS_AXIS_TVALID && s_ready;
    assign rx_cnt_nx = !rx_acc ? rx_cnt_q :
                       (rx_cnt_q == '1) ? rx_cnt_q : rx_cnt_q + PRM_BEATS_W'(1);
    assign ret_end   = tlast_seen_q || (rx_acc && iS_AXIS_TLAST);
    // The idle count expires on the cycle it would step onto all ones.
    assign tout_hit  = !rx_acc && (tout_cnt_q == TOUT_LAST);

    always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
        if (!iSYS_RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        fin_tout = 1'b0;
        case (state)
            ST_IDLE: begin
                if (iSTART) begin
                    state_nx = (iTX_BEATS == '0) ? ST_WAIT : ST_SEND;
                end
            end
            ST_SEND: begin
                if (m_acc && m_tlast_q) begin
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ret_end) begin
                    state_nx = ST_DONE;
                end else if (tout_hit) begin
                    state_nx = ST_DONE;
                    fin_tout = 1'b1;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Transmit side: the output register always holds the beat on offer.
    always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
        if (!iSYS_RST) begin
            mode_q     <= '0;
            seed_q     <= '0;
            tx_beats_q <= '0;
            rx_beats_q <= '0;
            beat_q     <= '0;
            base_q     <= '0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tlast_q  <= 1'b0;
        end else if (start_go) begin
            mode_q     <= iMODE;
            seed_q     <= iSEED;
            tx_beats_q <= iTX_BEATS;
            rx_beats_q <= iRX_BEATS;
            beat_q     <= PRM_BEATS_W'(1);
            base_q     <= PRM_COEF'(LANES);
            if (iTX_BEATS != '0) begin
                m_tvalid_q <= 1'b1;
                m_tdata_q  <= pack_beat(iMODE, iSEED, '0);
                m_tlast_q  <= (iTX_BEATS == PRM_BEATS_W'(1));
            end
        end else if ((state == ST_SEND) && m_acc) begin
            if (m_tlast_q) begin
                m_tvalid_q <= 1'b0;
                m_tlast_q  <= 1'b0;
            end else begin
                m_tdata_q <= pack_beat(mode_q, seed_q, base_q);
                m_tlast_q <= (beat_q == tx_beats_q - PRM_BEATS_W'(1));
                beat_q    <= beat_q + PRM_BEATS_W'(1);
                base_q    <= base_q + PRM_COEF'(LANES);
            end
        end
    end

    // Return side: beat count, early TLAST capture, idle timer and verdict.
    always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
        if (!iSYS_RST) begin
            rx_cnt_q     <= '0;
            err_q        <= 1'b0;
            tout_flag_q  <= 1'b0;
            tlast_seen_q <= 1'b0;
            tout_cnt_q   <= '0;
        end else begin
            if (start_go) begin
                rx_cnt_q     <= '0;
                err_q        <= 1'b0;
                tout_flag_q  <= 1'b0;
                tlast_seen_q <= 1'b0;
            end else begin
                rx_cnt_q <= rx_cnt_nx;
                if ((state == ST_SEND) && rx_acc && iS_AXIS_TLAST) begin
                    tlast_seen_q <= 1'b1;
                end
            end

            if ((state != ST_WAIT) && (state_nx == ST_WAIT)) begin
                tout_cnt_q <= '0;
            end else if (state == ST_WAIT) begin
                tout_cnt_q <= rx_acc ? '0 : tout_cnt_q + PRM_TOUT_W'(1);
            end

            if ((state == ST_WAIT) && (state_nx == ST_DONE)) begin
                err_q       <= fin_tout || (rx_cnt_nx != rx_beats_q);
                tout_flag_q <= fin_tout;
            end
        end
    end

    assign unused_rx_data = ^iS_AXIS_TDATA;

    assign oM_AXIS_TVALID = m_tvalid_q;
    assign oM_AXIS_TDATA  = m_tdata_q;
    assign oM_AXIS_TKEEP  = '1;
    assign oM_AXIS_TLAST  = m_tlast_q;
    assign oS_AXIS_TREADY = s_ready;
    assign oBUSY          = (state != ST_IDLE);
    assign oDONE          = (state == ST_DONE);
    assign oRX_CNT        = rx_cnt_q;
    assign oERR           = err_q;
    assign oTIMEOUT       = tout_flag_q;
    assign oDBG_STATE     = state;

endmodule

// File: tb/tb_axis_stim_gen.sv
// Directed bench for axis_stim_gen: a beat-list model of the transmit stream
// checked every valid cycle, plus literal checks of run results.
module tb_axis_stim_gen;

  localparam int DAXI = 64;
  localparam int COEF = 32;
  localparam int BW   = 12;
  localparam int TW   = 4;
  localparam int L    = DAXI / COEF;
  localparam int W    = DAXI + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      mode = '0;
  logic [COEF-1:0] seed = '0;
  logic [BW-1:0]   tx_beats = '0;
  logic [BW-1:0]   rx_beats = '0;
  logic            m_tvalid;
  logic            m_tready = 1'b1;
  logic [DAXI-1:0] m_tdata;
  logic [DAXI/8-1:0] m_tkeep;
  logic            m_tlast;
  logic            s_tvalid = 1'b0;
  logic            s_tready;
  logic [DAXI-1:0] s_tdata = '0;
  logic            s_tlast = 1'b0;
  logic            busy;
  logic            done;
  logic [BW-1:0]   rx_cnt;
  logic            err;
  logic            tout;
  logic [1:0]      dbg_state;

  always #5 clk = ~clk;

  axis_stim_gen #(
    .PRM_DAXI(DAXI), .PRM_COEF(COEF), .PRM_BEATS_W(BW), .PRM_TOUT_W(TW)
  ) dut (
    .iSYS_CLK(clk), .iSYS_RST(rst_n), .iSTART(start), .iMODE(mode),
    .iSEED(seed), .iTX_BEATS(tx_beats), .iRX_BEATS(rx_beats),
    .oM_AXIS_TVALID(m_tvalid), .iM_AXIS_TREADY(m_tready),
    .oM_AXIS_TDATA(m_tdata), .oM_AXIS_TKEEP(m_tkeep), .oM_AXIS_TLAST(m_tlast),
    .iS_AXIS_TVALID(s_tvalid), .oS_AXIS_TREADY(s_tready),
    .iS_AXIS_TDATA(s_tdata), .iS_AXIS_TLAST(s_tlast),
    .oBUSY(busy), .oDONE(done), .oRX_CNT(rx_cnt), .oERR(err),
    .oTIMEOUT(tout), .oDBG_STATE(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic chk_en = 1'b0;
  logic [W-1:0] exp_q[$];

  int acc_n = 0;
  int last_acc_cyc = 0;
  int done_n = 0;
  int done_cyc = 0;
  logic [DAXI-1:0] got_first = '0;
  logic [DAXI-1:0] got_last = '0;

  int   ret_left = 0;
  logic ret_tlast_en = 1'b0;
  logic rdy_rand = 1'b0;
  logic ret_acc = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Coefficient i = b*L + k in lane k, values taken modulo 2^COEF.
  function automatic logic [DAXI-1:0] model_beat(input int md, input logic [COEF-1:0] sd, input int b);
    logic [DAXI-1:0] r;
    logic [COEF-1:0] v;
    int i;
    r = '0;
    for (int k = 0; k < L; k++) begin
      i = b * L + k;
      case (md)
        0:       v = sd + COEF'(i);
        1:       v = sd - COEF'(i);
        2:       v = sd;
        default: v = (i % 2 == 0) ? sd : -sd;
      endcase
      r[k*COEF +: COEF] = v;
    end
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: every valid beat must equal the head of the expected list.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      if (m_tvalid) begin
        if (exp_q.size() == 0) begin
          chk("tx_valid_unexpected", W'(m_tvalid), '0);
        end else begin
          chk("tx_beat", {m_tlast, m_tdata}, exp_q[0]);
          if (m_tready) begin
            if (acc_n == 0) got_first = m_tdata;
            got_last = m_tdata;
            acc_n++;
            last_acc_cyc = cyc;
            void'(exp_q.pop_front());
          end
        end
      end
      if (done) begin
        done_n++;
        done_cyc = cyc;
      end
    end
  end

  // Return-stream and TREADY driver.
  initial begin : drv
    forever begin
      @(negedge clk);
      ret_acc = s_tvalid && s_tready;
      @(posedge clk);
      #1;
      if (!rst_n) ret_left = 0;
      else if (ret_acc && ret_left > 0) ret_left--;
      s_tvalid = (ret_left > 0);
      s_tlast  = (ret_left == 1) && ret_tlast_en;
      s_tdata  = {$urandom, $urandom};
      m_tready = rdy_rand ? ($urandom_range(0, 9) != 0) : 1'b1;
    end
  end

  task automatic start_run(input int md, input logic [COEF-1:0] sd, input int tx, input int rx,
                           input int ret_n, input logic tl_en, input logic rnd);
    @(negedge clk);
    exp_q.delete();
    for (int b = 0; b < tx; b++) exp_q.push_back({(b == tx - 1), model_beat(md, sd, b)});
    acc_n = 0;
    done_n = 0;
    ret_left = ret_n;
    ret_tlast_en = tl_en;
    rdy_rand = rnd;
    mode = 2'(md);
    seed = sd;
    tx_beats = BW'(tx);
    rx_beats = BW'(rx);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", W'(busy), W'(1));
    chk("tvalid_after_start", W'(m_tvalid), W'(tx != 0));
  endtask

  task automatic finish_run(input string name, input int exp_cnt, input logic exp_err, input logic exp_tout);
    int k;
    k = 0;
    while (done_n == 0 && k < 6000) begin
      @(posedge clk);
      k++;
    end
    if (done_n == 0) begin
      chk({name, "_done_seen"}, W'(0), W'(1));
    end else begin
      @(negedge clk);
      chk({name, "_done_pulses"}, W'(done_n), W'(1));
      chk({name, "_done_low"}, W'(done), W'(0));
      chk({name, "_busy_low"}, W'(busy), W'(0));
      chk({name, "_rx_cnt"}, W'(rx_cnt), W'(exp_cnt));
      chk({name, "_err"}, W'(err), W'(exp_err));
      chk({name, "_timeout"}, W'(tout), W'(exp_tout));
      chk({name, "_beats_left"}, W'(exp_q.size()), W'(0));
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k;
    // Model pins against hand-computed values.
    chk("model_pin_m0", W'(model_beat(0, 32'd1, 0)), W'(64'h00000002_00000001));
    chk("model_pin_m1", W'(model_beat(1, 32'hFFFFFFFF, 1)), W'(64'hFFFFFFFC_FFFFFFFD));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", W'(m_tvalid), '0);
    chk("rst_tkeep", W'(m_tkeep), W'(8'hFF));
    chk("rst_outputs", W'({busy, done, rx_cnt, err, tout, s_tready, m_tlast}), '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    start_run(0, 32'd1, 2048, 2048, 2048, 1'b1, 1'b0);
    finish_run("m0_loop", 2048, 1'b0, 1'b0);
    chk("m0_first", W'(got_first), W'(64'h00000002_00000001));
    chk("m0_last", W'(got_last), W'(64'h00001000_00000FFF));

    start_run(1, 32'hFFFFFFFF, 4, 4, 4, 1'b1, 1'b0);
    finish_run("m1", 4, 1'b0, 1'b0);
    chk("m1_first", W'(got_first), W'(64'hFFFFFFFE_FFFFFFFF));
    chk("m1_last", W'(got_last), W'(64'hFFFFFFF8_FFFFFFF9));

    start_run(0, 32'd3, 300, 300, 300, 1'b1, 1'b1);
    finish_run("stall", 300, 1'b0, 1'b0);
    chk("stall_last", W'(got_last), W'(64'h0000025A_00000259));
    rdy_rand = 1'b0;

    start_run(2, 32'hA5, 10, 8, 6, 1'b1, 1'b0);
    finish_run("short_ret", 6, 1'b1, 1'b0);
    chk("m2_first", W'(got_first), W'(64'h000000A5_000000A5));

    start_run(3, 32'd5, 3, 4, 0, 1'b0, 1'b0);
    finish_run("tout", 0, 1'b1, 1'b1);
    chk("tout_latency", W'(done_cyc - last_acc_cyc), W'(16));
    chk("m3_first", W'(got_first), W'(64'hFFFFFFFB_00000005));

    start_run(0, 32'd9, 0, 1, 1, 1'b1, 1'b0);
    finish_run("tx_zero", 1, 1'b0, 1'b0);

    start_run(0, 32'd1, 2048, 2048, 0, 1'b0, 1'b0);
    k = 0;
    while (acc_n < 100 && k < 1000) begin
      @(posedge clk);
      k++;
    end
    chk("abort_reached_beat100", W'(acc_n >= 100), W'(1));
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_tvalid", W'(m_tvalid), '0);
    chk("abort_tkeep", W'(m_tkeep), W'(8'hFF));
    chk("abort_outputs", W'({busy, done, rx_cnt, err, tout, s_tready, m_tlast}), '0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_no_done", W'(done_n), '0);

    start_run(0, 32'd7, 4, 4, 4, 1'b1, 1'b0);
    finish_run("restart", 4, 1'b0, 1'b0);
    chk("restart_first", W'(got_first), W'(64'h00000008_00000007));

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axis_stim_gen.md
# axis_stim_gen

Synthesizable AXI-Stream stimulus generator and response sink for the MDL accelerator datapath. It has two roles: on-chip self-test and the bench driver for the accelerator. It emits a parametrised burst of packed coefficients on a master stream, with selectable pattern, lane count and length. It accepts the accelerator's return stream, counts beats and checks TLAST position. It reports completion, length error or timeout, replacing hand-coded burst loops for Keccak/PWM/NTT runs.

## Interface
Parameters:
- PRM_DAXI, 64, stream data width in bits
- PRM_COEF, 32, coefficient width; lanes L = PRM_DAXI/PRM_COEF (integer, ≥1)
- PRM_BEATS_W, 12, width of beat counters
- PRM_TOUT_W, 16, width of the return-stream idle timeout counter

Ports:
- iSYS_CLK  in  1  single clock
- iSYS_RST  in  1  asynchronous, active-low reset
- iSTART  in  1  start pulse; sampled only in IDLE
- iMODE  in  2  pattern: 0 increment, 1 decrement, 2 constant, 3 alternating ±SEED
- iSEED  in  PRM_COEF  pattern seed
- iTX_BEATS  in  PRM_BEATS_W  beats to send
- iRX_BEATS  in  PRM_BEATS_W  expected return beats
- oM_AXIS_TVALID / iM_AXIS_TREADY  out/in  1  output handshake
- oM_AXIS_TDATA  out  PRM_DAXI  packed coefficients
- oM_AXIS_TKEEP  out  PRM_DAXI/8  all ones
- oM_AXIS_TLAST  out  1  last transmit beat
- iS_AXIS_TVALID / oS_AXIS_TREADY  in/out  1  return handshake
- iS_AXIS_TDATA  in  PRM_DAXI  return data (discarded)
- iS_AXIS_TLAST  in  1  return end marker
- oBUSY  out  1  run in progress
- oDONE  out  1  one-cycle completion pulse
- oRX_CNT  out  PRM_BEATS_W  accepted return beats of the last run
- oERR  out  1  return length ≠ iRX_BEATS
- oTIMEOUT  out  1  run ended by timeout

## Operation
- States: IDLE, SEND, WAIT, DONE.
- IDLE: iSTART=1 latches iMODE, iSEED, iTX_BEATS and iRX_BEATS, and clears oRX_CNT, oERR and oTIMEOUT. Next state is SEND, or WAIT if iTX_BEATS=0.
- SEND: beat b carries coefficient index i=b·L+k in lane k. Lane 0 occupies the LSBs.
- Coefficient value V(i), modulo 2^PRM_COEF: mode0 SEED+i; mode1 SEED−i; mode2 SEED; mode3 SEED if i even, else −SEED.
- oM_AXIS_TLAST=1 on beat iTX_BEATS−1 only. After the last beat is accepted, go to WAIT.
- Return sink: oS_AXIS_TREADY=1 in SEND and WAIT, 0 otherwise. Each accepted beat increments oRX_CNT, saturating at all ones.
- An accepted return TLAST during SEND is recorded. WAIT is then left on its first cycle.
- WAIT: a recorded or accepted return TLAST leads to DONE. oERR = (final beat count ≠ latched iRX_BEATS).
- Timeout counter: zeroed on entry to WAIT and on every accepted return beat, incremented otherwise. At all ones, go to DONE with oTIMEOUT=1 and oERR=1.
- DONE: oDONE=1 for one cycle, then IDLE. oRX_CNT, oERR and oTIMEOUT hold until the next start.
- iSTART outside IDLE is ignored. Return beats outside SEND/WAIT are not accepted.

## Timing
- Reset values: all outputs 0 except oM_AXIS_TKEEP, which is all ones. State is IDLE and counters are 0.
- Start sampled at edge t gives oM_AXIS_TVALID=1 with beat 0 after edge t; first beat visible in cycle t+1.
- oBUSY=1 from cycle t+1 through the DONE cycle.
- TVALID, TDATA and TLAST are registered and held stable while TREADY=0. TVALID never drops before acceptance.
- With TREADY held at 1, the output sends one beat per cycle with no bubbles.
- Reset asserted mid-run aborts immediately: TVALID=0, IDLE, no oDONE.

## Test plan
- Mode0, SEED=1, TX=2048, RX=2048, L=2, TREADY=1; loopback returns 2048 beats with TLAST on the last → beat0=0x00000002_00000001, beat2047=0x00001000_00000FFF with TLAST; oDONE pulse; oRX_CNT=2048; oERR=0.
- Mode1, SEED=0xFFFFFFFF, TX=4 → beats 0xFFFFFFFE_FFFFFFFF, 0xFFFFFFFC_FFFFFFFD, …; TLAST only on beat 3.
- Random TREADY stalls (about 10% low) on a mode0 run → TDATA/TLAST stable during stalls; sequence identical to the unstalled run.
- RX expects 8 but the DUT sends TLAST on its 6th beat → oRX_CNT=6, oERR=1, oTIMEOUT=0.
- No return beats, PRM_TOUT_W=4 → oDONE exactly 15 cycles after WAIT entry; oTIMEOUT=1, oERR=1.
- Reset deasserted and reasserted at beat 100 of 2048 → all outputs at reset values next cycle; a new iSTART restarts from beat 0.
